axi4_slave_resp_channel: RTL and testbench

AXI4_SLAVE_RESP_CHANNEL -- requirements
Module: axi4_slave_resp_channel

---
 rtl/axi4_slave_resp_channel.sv | 99 +++++++++
 tb/tb_axi4_slave_resp_channel.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/axi4_slave_resp_channel.sv
// AXI4 write-response channel: queues {bid,bresp} per completed burst and presents them on B.
// Latency: 1 cycle from b_transfer_done to bvalid. Backpressure: bready=0 holds the head; a full queue drops pushes unless popped.
module axi4_slave_resp_channel #(
    parameter int          ID_WIDTH    = 4,
    parameter int          RESP_DEPTH  = 4,
    parameter logic [15:0] STALL_LIMIT = 16'd1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          b_transfer_done,
    input  logic [ID_WIDTH-1:0]           b_bid,
    input  logic [1:0]                    b_bresp,
    input  logic                          bready,
    output logic                          bvalid,
    output logic [ID_WIDTH-1:0]           bid,
    output logic [1:0]                    bresp,
    output logic                          resp_full,
    output logic [$clog2(RESP_DEPTH):0]   resp_count,
    output logic                          resp_overflow,
    output logic                          stall_err
);
    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ID_WIDTH + 2;

    typedef enum logic {B_IDLE, B_VALID} b_state_t;

    b_state_t        state;
    logic [EW-1:0]   mem [RESP_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0]   count_after_pop, count_nxt;
    logic [EW-1:0]   head_nxt;
    logic [15:0]     stall_cnt, stall_nxt;
    logic            push, pop;

    assign resp_full = (resp_count == CW'(RESP_DEPTH));
    assign pop       = bvalid & bready;
    assign push      = b_transfer_done & (~resp_full | pop);

    // The output register is loaded with the next head; when the queue would
    // otherwise be empty that head is the entry being written this cycle.
    always_comb begin
        rd_nxt          = pop ? rd_ptr + 1'b1 : rd_ptr;
        count_after_pop = resp_count - {{PW{1'b0}}, pop};
        count_nxt       = count_after_pop + {{PW{1'b0}}, push};
        head_nxt        = (count_after_pop == '0) ? {b_bid, b_bresp} : mem[rd_nxt];
        stall_nxt       = 16'd0;
        if (bvalid && !bready)
            stall_nxt = (stall_cnt == 16'hFFFF) ? stall_cnt : stall_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {b_bid, b_bresp};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= B_IDLE;
            bvalid        <= 1'b0;
            bid           <= '0;
            bresp         <= 2'b00;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            resp_count    <= '0;
            resp_overflow <= 1'b0;
            stall_cnt     <= 16'd0;
            stall_err     <= 1'b0;
        end else begin
            case (state)
                B_IDLE: if (push) begin
                    state  <= B_VALID;
                    bvalid <= 1'b1;
                end
                B_VALID: if (pop && resp_count == CW'(1) && !push) begin
                    state  <= B_IDLE;
                    bvalid <= 1'b0;
                end
                default: begin
                    state  <= B_IDLE;
                    bvalid <= 1'b0;
                end
            endcase
            if (count_nxt != '0)
                {bid, bresp} <= head_nxt;
            else
                {bid, bresp} <= '0;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr     <= rd_nxt;
            resp_count <= count_nxt;
            if (b_transfer_done && !push)
                resp_overflow <= 1'b1;
            stall_cnt <= stall_nxt;
            if (stall_nxt == STALL_LIMIT)
                stall_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi4_slave_resp_channel.sv
// Directed plus randomized bench for axi4_slave_resp_channel against a queue-based reference model.
module tb_axi4_slave_resp_channel;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b_transfer_done = 1'b0;
    logic [3:0] b_bid = '0;
    logic [1:0] b_bresp = '0;
    logic       bready = 1'b0;
    logic       bvalid;
    logic [3:0] bid;
    logic [1:0] bresp;
    logic       resp_full;
    logic [2:0] resp_count;
    logic       resp_overflow;
    logic       stall_err;

    int n_checks = 0;
    int n_err    = 0;

    logic [5:0] mq[$];
    logic       m_ovf   = 1'b0;
    logic       m_serr  = 1'b0;
    int         m_stall = 0;

    axi4_slave_resp_channel #(.ID_WIDTH(4), .RESP_DEPTH(DEPTH), .STALL_LIMIT(16'(LIMIT))) dut (
        .clk(clk), .rst(rst), .b_transfer_done(b_transfer_done), .b_bid(b_bid),
        .b_bresp(b_bresp), .bready(bready), .bvalid(bvalid), .bid(bid), .bresp(bresp),
        .resp_full(resp_full), .resp_count(resp_count), .resp_overflow(resp_overflow),
        .stall_err(stall_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        logic [5:0] h;
        h = (mq.size() > 0) ? mq[0] : 6'd0;
        chk({tag, ".bvalid"}, 32'(bvalid), 32'(mq.size() > 0));
        chk({tag, ".bid"}, 32'(bid), 32'(h[5:2]));
        chk({tag, ".bresp"}, 32'(bresp), 32'(h[1:0]));
        chk({tag, ".count"}, 32'(resp_count), 32'(mq.size()));
        chk({tag, ".full"}, 32'(resp_full), 32'(mq.size() == DEPTH));
        chk({tag, ".ovf"}, 32'(resp_overflow), 32'(m_ovf));
        chk({tag, ".serr"}, 32'(stall_err), 32'(m_serr));
    endtask

    // One clock: apply inputs, advance the model by the handshake rules, compare.
    task automatic cycle(input string tag, input logic d, input logic [3:0] id,
                         input logic [1:0] rs, input logic rdy);
        logic had, pp, ps;
        b_transfer_done = d; b_bid = id; b_bresp = rs; bready = rdy;
        @(posedge clk);
        had = mq.size() > 0;
        pp  = had && rdy;
        ps  = d && (mq.size() < DEPTH || pp);
        if (pp) void'(mq.pop_front());
        if (ps) mq.push_back({id, rs});
        else if (d) m_ovf = 1'b1;
        if (had && !rdy) m_stall = (m_stall < 65535) ? m_stall + 1 : m_stall;
        else m_stall = 0;
        if (m_stall == LIMIT) m_serr = 1'b1;
        #1;
        compare_all(tag);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0; m_serr = 1'b0; m_stall = 0;
    endtask

    task automatic do_reset(input string tag);
        b_transfer_done = 1'b0; bready = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2;
        compare_all("por");
        @(posedge clk); #1;
        rst = 1'b0;

        // single response with bready=1
        cycle("single_push", 1'b1, 4'h5, 2'b00, 1'b1);
        chk("single_bid", 32'(bid), 32'h5);
        cycle("single_pop", 1'b0, 4'h0, 2'b00, 1'b1);
        chk("single_gone", 32'(bvalid), 32'h0);

        // backpressure fill, then drain in order
        do_reset("rst_bp");
        for (int i = 1; i <= 4; i++)
            cycle("bp_fill", 1'b1, 4'(i), (i == 3) ? 2'b11 : 2'b00, 1'b0);
        chk("bp_full", 32'(resp_full), 32'h1);
        cycle("bp_hold", 1'b0, 4'h0, 2'b00, 1'b0);
        chk("bp_hold_bid", 32'(bid), 32'h1);

        // overflow while full
        cycle("ovf_push", 1'b1, 4'h9, 2'b00, 1'b0);
        chk("ovf_flag", 32'(resp_overflow), 32'h1);
        chk("ovf_count", 32'(resp_count), 32'h4);
        for (int i = 0; i < 5; i++) begin
            cycle("bp_drain", 1'b0, 4'h0, 2'b00, 1'b1);
            chk("no_id9", 32'(bvalid && bid == 4'h9), 32'h0);
        end

        // simultaneous push and pop on a full queue
        do_reset("rst_pp");
        for (int i = 0; i < 4; i++)
            cycle("pp_fill", 1'b1, 4'(10 + i), 2'b01, 1'b0);
        cycle("pp_both", 1'b1, 4'h7, 2'b10, 1'b1);
        chk("pp_count", 32'(resp_count), 32'h4);
        chk("pp_ovf", 32'(resp_overflow), 32'h0);
        for (int i = 0; i < 3; i++)
            cycle("pp_drain", 1'b0, 4'h0, 2'b00, 1'b1);
        chk("pp_last_id7", 32'(bid), 32'h7);
        cycle("pp_empty", 1'b0, 4'h0, 2'b00, 1'b1);

        // stall detection
        do_reset("rst_stall");
        cycle("st_push", 1'b1, 4'h6, 2'b00, 1'b0);
        for (int i = 0; i < 7; i++)
            cycle("st_wait", 1'b0, 4'h0, 2'b00, 1'b0);
        chk("st_before", 32'(stall_err), 32'h0);
        for (int i = 0; i < 3; i++)
            cycle("st_wait2", 1'b0, 4'h0, 2'b00, 1'b0);
        chk("st_after", 32'(stall_err), 32'h1);
        chk("st_held_bid", 32'(bid), 32'h6);
        cycle("st_hs", 1'b0, 4'h0, 2'b00, 1'b1);
        chk("st_sticky", 32'(stall_err), 32'h1);

        // reset with entries queued: async clear, nothing emitted afterwards
        do_reset("rst_mid0");
        for (int i = 0; i < 3; i++)
            cycle("mid_fill", 1'b1, 4'(i + 2), 2'b00, 1'b0);
        cycle("mid_ovf", 1'b0, 4'h0, 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid_bvalid_async", 32'(bvalid), 32'h0);
        chk("mid_count_async", 32'(resp_count), 32'h0);
        compare_all("mid_async");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            cycle("mid_after", 1'b0, 4'h0, 2'b00, 1'b1);

        // randomized traffic against the model
        do_reset("rst_rand");
        for (int i = 0; i < 400; i++)
            cycle("rand", 1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom),
                  ($urandom_range(0, 3) != 0));
        for (int i = 0; i < 6; i++)
            cycle("rand_drain", 1'b0, 4'h0, 2'b00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
